// File: rtl/event_priority_encoder.sv
// Latches single-cycle event strobes into a pending set and presents them one at a
// time, lowest index first, as binary indices over a valid/ready handshake.
module event_priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             overflow,
    input  logic             clr_ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [N-1:0]     new_ev;
    logic [N-1:0]     cand;
    logic [IDX_W-1:0] low_idx;
    logic             slot_free;

    assign new_ev    = en ? req : '0;
    assign cand      = pending | new_ev;
    assign slot_free = (state == IDLE) || out_ready;
    assign out_valid = (state == HOLD);

    // NOTE: low_idx gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) low_idx = IDX_W'(i);
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_idx  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            // A repeat of an already-pending event is lost; setting beats clearing.
            if (|(new_ev & pending)) overflow <= 1'b1;
            else if (clr_ovf)        overflow <= 1'b0;

            if (slot_free) begin
                if (cand != '0) begin
                    state   <= HOLD;
                    out_idx <= low_idx;
                    pending <= cand & (cand - N'(1));
                end else begin
                    state   <= IDLE;
                    pending <= '0;
                end
            end else begin
                // Stalled: the presented index stays, new arrivals only accumulate.
                pending <= cand;
            end
        end
    end

endmodule
